// File: rtl/spram_arb_pkg.sv
// Shared constants for the two-requester single-port RAM arbiter:
// default geometry and the FSM state encodings.
package spram_arb_pkg;

    localparam int AWIDTH_DEF    = 11;
    localparam int DWIDTH_DEF    = 60;
    localparam int NUM_WORDS_DEF = 2048;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOCK0 = 2'd1;
    localparam logic [1:0] ST_LOCK1 = 2'd2;

    // Lock state owned by the given requester index.
    function automatic logic [1:0] lock_state(input logic req_id);
        return req_id ? ST_LOCK1 : ST_LOCK0;
    endfunction

endpackage

// File: rtl/spram_rr_arbiter_if.sv
// Request/response bundle between two RAM clients (master side) and the
// arbiter (slave side).
interface spram_rr_arbiter_if
    import spram_arb_pkg::*;
#(
    parameter int AWIDTH = AWIDTH_DEF,
    parameter int DWIDTH = DWIDTH_DEF
);
    logic              req0_valid;
    logic              req0_ready;
    logic              req0_wren;
    logic              req0_lock;
    logic [AWIDTH-1:0] req0_addr;
    logic [DWIDTH-1:0] req0_data;
    logic              req1_valid;
    logic              req1_ready;
    logic              req1_wren;
    logic              req1_lock;
    logic [AWIDTH-1:0] req1_addr;
    logic [DWIDTH-1:0] req1_data;
    logic              rsp0_valid;
    logic              rsp1_valid;
    logic [DWIDTH-1:0] rsp_data;
    logic              busy;

    modport master (
        output req0_valid, req0_wren, req0_lock, req0_addr, req0_data,
        output req1_valid, req1_wren, req1_lock, req1_addr, req1_data,
        input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data, busy
    );

    modport slave (
        input  req0_valid, req0_wren, req0_lock, req0_addr, req0_data,
        input  req1_valid, req1_wren, req1_lock, req1_addr, req1_data,
        output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data, busy
    );
endinterface

// File: rtl/spram_2048_60bit.sv
// Single-port synchronous RAM; the output register holds its value on
// write cycles so a pending read response is never disturbed.
module spram_2048_60bit
    import spram_arb_pkg::*;
#(
    parameter int AWIDTH    = AWIDTH_DEF,
    parameter int DWIDTH    = DWIDTH_DEF,
    parameter int NUM_WORDS = NUM_WORDS_DEF
) (
    input  logic              clk,
    input  logic [AWIDTH-1:0] address,
    input  logic              wren,
    input  logic [DWIDTH-1:0] data,
    output logic [DWIDTH-1:0] out
);
    logic [DWIDTH-1:0] mem_r [NUM_WORDS];

    // Write port, or registered read when not writing.
    always_ff @(posedge clk) begin
        if (wren) begin
            mem_r[address] <= data;
        end else begin
            out <= mem_r[address];
        end
    end
endmodule

// File: rtl/spram_rr_arbiter.sv
// Round-robin arbiter with optional grant locking that shares one
// single-port RAM between two requesters.
module spram_rr_arbiter
    import spram_arb_pkg::*;
#(
    parameter int AWIDTH    = AWIDTH_DEF,
    parameter int DWIDTH    = DWIDTH_DEF,
    parameter int NUM_WORDS = NUM_WORDS_DEF
) (
    input  logic             clk,
    input  logic             reset,
    spram_rr_arbiter_if.slave bus
);
    logic [1:0]        state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              rsp0_q, rsp1_q, busy_q;
    logic [AWIDTH-1:0] addr_q;
    logic              gnt0_s, gnt1_s;
    logic [AWIDTH-1:0] ram_addr_s;
    logic [DWIDTH-1:0] ram_data_s;
    logic              ram_wren_s;
    logic [DWIDTH-1:0] ram_out_s;

    // Grant decision; reset suppresses any grant in the same cycle.
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (reset) begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.req0_valid && bus.req1_valid) begin
                        gnt0_s = last_grant_q;
                        gnt1_s = !last_grant_q;
                    end else begin
                        gnt0_s = bus.req0_valid;
                        gnt1_s = bus.req1_valid;
                    end
                end
                ST_LOCK0: gnt0_s = bus.req0_valid;
                ST_LOCK1: gnt1_s = bus.req1_valid;
                default: begin
                    gnt0_s = 1'b0;
                    gnt1_s = 1'b0;
                end
            endcase
        end
    end

    // Next state: a grant picks the lock state or releases to idle.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        if (gnt0_s) begin
            last_grant_d = 1'b0;
            state_d      = bus.req0_lock ? lock_state(1'b0) : ST_IDLE;
        end else if (gnt1_s) begin
            last_grant_d = 1'b1;
            state_d      = bus.req1_lock ? lock_state(1'b1) : ST_IDLE;
        end else if ((state_q == ST_LOCK0) || (state_q == ST_LOCK1)) begin
            state_d = state_q;
        end else begin
            state_d = ST_IDLE;
        end
    end

    // RAM port mux; with no grant the address parks on the last one used.
    always_comb begin
        ram_addr_s = addr_q;
        ram_data_s = bus.req1_data;
        ram_wren_s = 1'b0;
        if (gnt0_s) begin
            ram_addr_s = bus.req0_addr;
            ram_data_s = bus.req0_data;
            ram_wren_s = bus.req0_wren;
        end else if (gnt1_s) begin
            ram_addr_s = bus.req1_addr;
            ram_data_s = bus.req1_data;
            ram_wren_s = bus.req1_wren;
        end else begin
            ram_addr_s = addr_q;
            ram_wren_s = 1'b0;
        end
    end

    // Control state, response strobes and busy flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            rsp0_q       <= 1'b0;
            rsp1_q       <= 1'b0;
            busy_q       <= 1'b0;
            addr_q       <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            rsp0_q       <= gnt0_s && !bus.req0_wren;
            rsp1_q       <= gnt1_s && !bus.req1_wren;
            busy_q       <= (state_d != ST_IDLE);
            if (gnt0_s || gnt1_s) begin
                addr_q <= ram_addr_s;
            end
        end
    end

    spram_2048_60bit #(
        .AWIDTH   (AWIDTH),
        .DWIDTH   (DWIDTH),
        .NUM_WORDS(NUM_WORDS)
    ) u_ram (
        .clk    (clk),
        .address(ram_addr_s),
        .wren   (ram_wren_s),
        .data   (ram_data_s),
        .out    (ram_out_s)
    );

    assign bus.req0_ready = gnt0_s;
    assign bus.req1_ready = gnt1_s;
    assign bus.rsp0_valid = rsp0_q;
    assign bus.rsp1_valid = rsp1_q;
    assign bus.rsp_data   = ram_out_s;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_spram_rr_arbiter.sv
// Directed scenarios plus randomized traffic, checked every cycle against
// a transaction-level model of the arbiter and RAM.
module tb_spram_rr_arbiter;
    localparam int AW = 11;
    localparam int DW = 60;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    spram_rr_arbiter_if #(.AWIDTH(AW), .DWIDTH(DW)) bus ();

    spram_rr_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .NUM_WORDS(2048)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // Model: owner of the lock (-1 none), last winner, pending response.
    int          lock_owner;
    int          last_winner;
    bit          pend0, pend1, pend_known, model_init;
    logic [DW-1:0] pend_data;
    logic [DW-1:0] mem_m [2048];
    bit          written [2048];

    bit          o_rdy0, o_rdy1, o_busy, o_rsp0, o_rsp1;
    logic [DW-1:0] o_data;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle(input bit rst,
                         input bit v0, input bit w0, input bit l0,
                         input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                         input bit v1, input bit w1, input bit l1,
                         input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        int winner;
        bit wr, lk;
        logic [AW-1:0] adr;
        logic [DW-1:0] dat;
        @(posedge clk);
        #1;
        reset = rst;
        bus.req0_valid = v0; bus.req0_wren = w0; bus.req0_lock = l0;
        bus.req0_addr = a0;  bus.req0_data = d0;
        bus.req1_valid = v1; bus.req1_wren = w1; bus.req1_lock = l1;
        bus.req1_addr = a1;  bus.req1_data = d1;
        #4;
        o_rdy0 = bus.req0_ready; o_rdy1 = bus.req1_ready; o_busy = bus.busy;
        o_rsp0 = bus.rsp0_valid; o_rsp1 = bus.rsp1_valid; o_data = bus.rsp_data;

        winner = -1;
        if (!rst) begin
            if (lock_owner == 0)      winner = v0 ? 0 : -1;
            else if (lock_owner == 1) winner = v1 ? 1 : -1;
            else if (v0 && v1)        winner = 1 - last_winner;
            else if (v0)              winner = 0;
            else if (v1)              winner = 1;
        end
        check("ready0", {63'd0, o_rdy0}, {63'd0, winner == 0});
        check("ready1", {63'd0, o_rdy1}, {63'd0, winner == 1});
        if (model_init) begin
            check("busy", {63'd0, o_busy}, {63'd0, lock_owner >= 0});
            check("rsp0_valid", {63'd0, o_rsp0}, {63'd0, pend0});
            check("rsp1_valid", {63'd0, o_rsp1}, {63'd0, pend1});
            if ((pend0 || pend1) && pend_known)
                check("rsp_data", {4'd0, o_data}, {4'd0, pend_data});
        end

        if (rst) begin
            lock_owner = -1; last_winner = 1; pend0 = 1'b0; pend1 = 1'b0;
            model_init = 1'b1;
        end else begin
            pend0 = 1'b0; pend1 = 1'b0;
            if (winner >= 0) begin
                wr  = (winner == 0) ? w0 : w1;
                lk  = (winner == 0) ? l0 : l1;
                adr = (winner == 0) ? a0 : a1;
                dat = (winner == 0) ? d0 : d1;
                last_winner = winner;
                lock_owner  = lk ? winner : -1;
                if (wr) begin
                    mem_m[adr]   = dat;
                    written[adr] = 1'b1;
                end else begin
                    pend0      = (winner == 0);
                    pend1      = (winner == 1);
                    pend_known = written[adr];
                    pend_data  = mem_m[adr];
                end
            end
        end
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 11'd0, 60'd0, 1'b0, 1'b0, 1'b0, 11'd0, 60'd0);
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 11'd0, 60'd0, 1'b0, 1'b0, 1'b0, 11'd0, 60'd0);
    endtask

    function automatic logic [AW-1:0] pick_addr();
        case ($urandom_range(0, 5))
            0: return 11'd0;
            1: return 11'd1;
            2: return 11'd3;
            3: return 11'd2046;
            4: return 11'd2047;
            default: return 11'($urandom_range(0, 2047));
        endcase
    endfunction

    initial begin
        int cnt0, cnt1;
        lock_owner = -1; last_winner = 1; pend0 = 1'b0; pend1 = 1'b0;
        pend_known = 1'b0; model_init = 1'b0; pend_data = '0;
        for (int i = 0; i < 2048; i++) begin
            written[i] = 1'b0;
            mem_m[i]   = '0;
        end
        reset = 1'b1;
        bus.req0_valid = 1'b0; bus.req0_wren = 1'b0; bus.req0_lock = 1'b0;
        bus.req0_addr = '0; bus.req0_data = '0;
        bus.req1_valid = 1'b0; bus.req1_wren = 1'b0; bus.req1_lock = 1'b0;
        bus.req1_addr = '0; bus.req1_data = '0;

        do_reset();
        do_reset();
        check("reset_busy", {63'd0, o_busy}, 64'd0);
        check("reset_rsp0", {63'd0, o_rsp0}, 64'd0);

        // Scenario 1: preload, then simultaneous reads; r0 wins the tie.
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 11'd5, 60'hA, 1'b0, 1'b0, 1'b0, 11'd0, 60'd0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 11'd0, 60'd0, 1'b1, 1'b1, 1'b0, 11'd9, 60'hB);
        do_reset();
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 11'd5, 60'd0, 1'b1, 1'b0, 1'b0, 11'd9, 60'd0);
        check("s1_ready0", {63'd0, o_rdy0}, 64'd1);
        check("s1_ready1", {63'd0, o_rdy1}, 64'd0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 11'd0, 60'd0, 1'b1, 1'b0, 1'b0, 11'd9, 60'd0);
        check("s1_rsp0", {63'd0, o_rsp0}, 64'd1);
        check("s1_data0", {4'd0, o_data}, 64'hA);
        check("s1_ready1_late", {63'd0, o_rdy1}, 64'd1);
        idle();
        check("s1_rsp1", {63'd0, o_rsp1}, 64'd1);
        check("s1_data1", {4'd0, o_data}, 64'hB);

        // Scenario 2: continuous contention alternates grants.
        do_reset();
        cnt0 = 0; cnt1 = 0;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 1'b0, 11'd5, 60'd0, 1'b1, 1'b0, 1'b0, 11'd9, 60'd0);
            check("s2_alternate", {63'd0, o_rdy0}, {63'd0, (i % 2) == 0});
            cnt0 += int'(o_rdy0);
            cnt1 += int'(o_rdy1);
        end
        check("s2_count0", 64'(cnt0), 64'd4);
        check("s2_count1", 64'(cnt1), 64'd4);
        idle();

        // Scenario 3: r0 locks across a read and a write; r1 waits.
        do_reset();
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 11'd3, 60'd0, 1'b1, 1'b0, 1'b0, 11'd9, 60'd0);
        check("s3_lock_ready0", {63'd0, o_rdy0}, 64'd1);
        check("s3_lock_ready1", {63'd0, o_rdy1}, 64'd0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 11'd3, 60'h123, 1'b1, 1'b0, 1'b0, 11'd9, 60'd0);
        check("s3_busy", {63'd0, o_busy}, 64'd1);
        check("s3_held_ready1", {63'd0, o_rdy1}, 64'd0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 11'd0, 60'd0, 1'b1, 1'b0, 1'b0, 11'd3, 60'd0);
        check("s3_released_busy", {63'd0, o_busy}, 64'd0);
        check("s3_release_ready1", {63'd0, o_rdy1}, 64'd1);
        idle();
        check("s3_new_data", {4'd0, o_data}, 64'h123);

        // Scenario 4: write then immediate read by the other requester.
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 11'd7, 60'hFFF, 1'b0, 1'b0, 1'b0, 11'd0, 60'd0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 11'd0, 60'd0, 1'b1, 1'b0, 1'b0, 11'd7, 60'd0);
        idle();
        check("s4_rsp1", {63'd0, o_rsp1}, 64'd1);
        check("s4_data", {4'd0, o_data}, 64'hFFF);

        // Scenario 5: reset while r1 holds the lock; the write in the reset cycle is dropped.
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 11'd0, 60'd0, 1'b1, 1'b0, 1'b1, 11'd9, 60'd0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 11'd5, 60'd0, 1'b0, 1'b0, 1'b0, 11'd0, 60'd0);
        check("s5_locked_ready0", {63'd0, o_rdy0}, 64'd0);
        check("s5_locked_busy", {63'd0, o_busy}, 64'd1);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 11'd5, 60'd0, 1'b1, 1'b1, 1'b0, 11'd7, 60'h555);
        check("s5_rst_ready0", {63'd0, o_rdy0}, 64'd0);
        check("s5_rst_ready1", {63'd0, o_rdy1}, 64'd0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 11'd5, 60'd0, 1'b0, 1'b0, 1'b0, 11'd0, 60'd0);
        check("s5_busy_after", {63'd0, o_busy}, 64'd0);
        check("s5_ready0_after", {63'd0, o_rdy0}, 64'd1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 11'd0, 60'd0, 1'b1, 1'b0, 1'b0, 11'd7, 60'd0);
        idle();
        check("s5_write_dropped", {4'd0, o_data}, 64'hFFF);

        // Scenario 6: extreme addresses.
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 11'd0, 60'h0AB_CDEF_0123_4567, 1'b0, 1'b0, 1'b0, 11'd0, 60'd0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 11'd0, 60'd0, 1'b1, 1'b1, 1'b0, 11'd2047, 60'hFED_CBA9_8765_4321);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 11'd2047, 60'd0, 1'b0, 1'b0, 1'b0, 11'd0, 60'd0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 11'd0, 60'd0, 1'b1, 1'b0, 1'b0, 11'd0, 60'd0);
        check("s6_data_top", {4'd0, o_data}, 64'hFED_CBA9_8765_4321);
        idle();
        check("s6_data_zero", {4'd0, o_data}, 64'h0AB_CDEF_0123_4567);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 63) == 0),
                  ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
                  ($urandom_range(0, 3) == 0), pick_addr(), {$urandom(), $urandom()} & 60'hFFF_FFFF_FFFF_FFFF,
                  ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
                  ($urandom_range(0, 3) == 0), pick_addr(), {$urandom(), $urandom()} & 60'hFFF_FFFF_FFFF_FFFF);
        end
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/spram_rr_arbiter.md
SPRAM_RR_ARBITER -- requirements
Module: spram_rr_arbiter

Interface
REQ-001 Parameter AWIDTH, default 11, SHALL set the RAM address width.
REQ-002 Parameter DWIDTH, default 60, SHALL set the RAM data width.
REQ-003 Parameter NUM_WORDS, default 2048, SHALL set the RAM depth (2**AWIDTH).
REQ-004 Port clk, input, 1 bit, SHALL be the single clock; all logic is rising-edge.
REQ-005 Port reset, input, 1 bit, SHALL be a synchronous, active-high reset.
REQ-006 Ports req0_valid and req1_valid, input, 1 bit each, SHALL mean the requester presents an access.
REQ-007 Ports req0_ready and req1_ready, output, 1 bit each, SHALL mean the access is granted this cycle.
REQ-008 Ports req0_wren and req1_wren, input, 1 bit each, SHALL select write (1) or read (0).
REQ-009 Ports req0_lock and req1_lock, input, 1 bit each, SHALL request that the grant be held after this access.
REQ-010 Ports req0_addr and req1_addr, input, AWIDTH each, SHALL carry the word address.
REQ-011 Ports req0_data and req1_data, input, DWIDTH each, SHALL carry the write data.
REQ-012 Ports rsp0_valid and rsp1_valid, output, 1 bit each, SHALL pulse when read data for that requester is on rsp_data.
REQ-013 Port rsp_data, output, DWIDTH, SHALL carry the shared read data.
REQ-014 Port busy, output, 1 bit, SHALL be high while a lock is held.

Function
REQ-015 A transfer SHALL occur on a cycle where reqN_valid and reqN_ready are both 1; at most one ready is high per cycle.
REQ-016 Ready SHALL be combinational from the valid inputs and registered state, and SHALL NOT depend on ready.
REQ-017 The FSM SHALL have three states: IDLE, LOCK0 and LOCK1.
REQ-018 In IDLE with one valid, that requester SHALL be granted.
REQ-019 In IDLE with both valid, the requester that is not last_grant SHALL be granted; last_grant then updates to the winner.
REQ-020 A granted transfer with reqN_lock=1 SHALL move the FSM to LOCKN.
REQ-021 In LOCKN only requester N SHALL be granted; the other ready SHALL stay 0 even if it is valid.
REQ-022 LOCKN SHALL return to IDLE after the first granted transfer from N that has lock=0.
REQ-023 In LOCKN, idle cycles with reqN_valid=0 SHALL NOT release the lock.
REQ-024 Only the granted requester's addr, data and wren SHALL drive the RAM in the grant cycle; with no grant, RAM wren is 0 and the address holds its last value.
REQ-025 A granted read SHALL produce rspN_valid=1 exactly 1 cycle later, with rsp_data equal to the RAM word at that cycle.
REQ-026 A granted write SHALL write the RAM at the grant edge and produce no response.
REQ-027 While writing, the RAM output SHALL hold its previous value; rsp_data is only meaningful when a rsp valid is high.
REQ-028 A read and then a write of the same address in back-to-back cycles SHALL return the old data.
REQ-029 A write and then a read of the same address in back-to-back cycles SHALL return the new data.
REQ-030 busy SHALL equal (state != IDLE), registered.

Reset
REQ-031 Reset SHALL force state=IDLE, last_grant=1 (so requester 0 wins the first tie), rsp0_valid=rsp1_valid=0 and busy=0.
REQ-032 Reset SHALL NOT clear RAM contents; rsp_data is undefined until the first read response.
REQ-033 If reset is asserted in the same cycle as a grant, that grant SHALL be suppressed: no ready, no write, no response.
REQ-034 Reset mid-lock SHALL release the lock immediately.

Structure
REQ-035 State encodings (IDLE/LOCK0/LOCK1) and the default widths SHALL live in the shared package spram_arb_pkg.
REQ-036 The storage SHALL be one instance of spram_2048_60bit (address, wren, data, out, clk); no other sub-module.

Verification
REQ-037 Scenario 1: after reset, both requesters read (r0 addr 5, r1 addr 9) with memory pre-written 0xA/0xB -> req0_ready first; rsp0_valid next cycle with 0xA; then r1 granted and rsp1_valid with 0xB.
REQ-038 Scenario 2: both requesters valid continuously for 8 cycles -> grants strictly alternate 0,1,0,1,..., with 4 grants each.
REQ-039 Scenario 3: r0 issues lock read of addr 3, then unlocked write of addr 3 = 0x123 while r1 is valid -> r1_ready=0 for both cycles, busy=1 between them, r1 granted the cycle after release.
REQ-040 Scenario 4: r0 writes addr 7 = 0xFFF, then r1 reads addr 7 on the next cycle -> rsp1_valid with 0xFFF.
REQ-041 Scenario 5: reset asserted while in LOCK1 with r0 valid -> next cycle busy=0 and r0 granted.
REQ-042 Scenario 6: addresses 0 and 2047 are written and read back by both requesters -> correct data, with no aliasing.
